// File: rtl/mux_scanner.sv
// Sequencer for an 8:1 mux: steps the selects through channels 0-7, holds each for
// DWELL cycles, samples the mux output on the last dwell cycle and publishes an 8-bit snapshot.
module mux_scanner #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       mux_out,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       busy,
    output logic       done,
    output logic [7:0] snapshot,
    output logic       valid
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(DWELL - 1);

    state_t      r_state;
    logic [2:0]  r_ch;
    logic [7:0]  r_cnt;
    logic [6:0]  r_shadow;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_snapshot;
    logic        r_valid;
    logic        w_dwell_end;

    assign w_dwell_end = (r_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ch       <= 3'd0;
            r_cnt      <= 8'd0;
            r_shadow   <= 7'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_snapshot <= 8'h00;
            r_valid    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= SCAN;
                        r_busy  <= 1'b1;
                        r_ch    <= 3'd0;
                        r_cnt   <= 8'd0;
                    end
                end
                SCAN: begin
                    if (!w_dwell_end) begin
                        r_cnt <= r_cnt + 8'd1;
                    end else if (r_ch != 3'd7) begin
                        r_shadow[r_ch] <= mux_out;
                        r_ch           <= r_ch + 3'd1;
                        r_cnt          <= 8'd0;
                    end else begin
                        // Channel 7 is taken straight from the mux so the snapshot lands atomically.
                        r_snapshot <= {mux_out, r_shadow};
                        r_done     <= 1'b1;
                        r_valid    <= 1'b1;
                        r_ch       <= 3'd0;
                        r_cnt      <= 8'd0;
                        if (!cont) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign {s2, s1, s0} = r_ch;
    assign busy         = r_busy;
    assign done         = r_done;
    assign snapshot     = r_snapshot;
    assign valid        = r_valid;

endmodule

// File: tb/tb_mux_scanner.sv
// Scoreboard bench for mux_scanner (DWELL=4); the 8:1 mux is modelled by indexing d with the selects.
module tb_mux_scanner;

    logic       clk;
    logic       rst;
    logic       start;
    logic       cont;
    logic       mux_out;
    logic       s0, s1, s2;
    logic       busy;
    logic       done;
    logic [7:0] snapshot;
    logic       valid;
    logic [7:0] d;
    logic [2:0] sel;

    int n_checks;
    int n_errors;
    int cyc;

    typedef struct {
        logic [7:0] snap;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    mux_scanner #(.DWELL(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cont     (cont),
        .mux_out  (mux_out),
        .s0       (s0),
        .s1       (s1),
        .s2       (s2),
        .busy     (busy),
        .done     (done),
        .snapshot (snapshot),
        .valid    (valid)
    );

    assign sel     = {s2, s1, s0};
    assign mux_out = d[sel];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [7:0] snap, input int at_cyc);
        exp_t t;
        t.snap = snap;
        t.cyc  = at_cyc;
        exp_q.push_back(t);
    endtask

    // Drives a one-cycle start; returns at the negedge right after the accepting edge (j=0).
    task automatic start_scan(input logic [7:0] exp_snap, input bit expect_done);
        @(negedge clk);
        start = 1'b1;
        if (expect_done) push_exp(exp_snap, cyc + 33);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: every done pulse must match the head of the scoreboard in time and value.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done=1 with snapshot %0h, required no done (cycle %0d)",
                         snapshot, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_time", cyc, mon_e.cyc);
                chk("snapshot", {24'd0, snapshot}, {24'd0, mon_e.snap});
                chk("valid_at_done", {31'd0, valid}, 32'd1);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        rst      = 1'b1;
        start    = 1'b0;
        cont     = 1'b0;
        d        = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_sel", {29'd0, sel}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_snapshot", {24'd0, snapshot}, 32'h00);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        rst = 1'b0;

        // Static pattern with select sequencing
        d = 8'hA5;
        start_scan(8'hA5, 1'b1);
        for (int j = 0; j < 32; j++) begin
            if (j == 0) chk("busy_first", {31'd0, busy}, 32'd1);
            if ((j % 4) == 0 || (j % 4) == 3) chk("sel_step", {29'd0, sel}, j / 4);
            @(negedge clk);
        end
        chk("static_busy_after", {31'd0, busy}, 32'd0);
        chk("static_valid", {31'd0, valid}, 32'd1);
        chk("static_snapshot", {24'd0, snapshot}, 32'hA5);
        chk("static_sel_idle", {29'd0, sel}, 32'd0);

        // Late-settle: only the last dwell cycle of channel 3 counts
        start_scan(8'h08, 1'b1);
        for (int j = 0; j < 33; j++) begin
            d = (j == 15) ? 8'h08 : 8'h00;
            @(negedge clk);
        end
        chk("late_settle_snap", {24'd0, snapshot}, 32'h08);

        // Early value that drops before the sample point has no effect
        start_scan(8'h00, 1'b1);
        for (int j = 0; j < 33; j++) begin
            d = (j >= 12 && j <= 14) ? 8'h08 : 8'h00;
            @(negedge clk);
        end
        chk("early_only_snap", {24'd0, snapshot}, 32'h00);

        // Continuous mode: two back-to-back scans, cont dropped during the second
        cont = 1'b1;
        d    = 8'h3C;
        start_scan(8'h3C, 1'b1);
        push_exp(8'hC3, cyc + 64);
        for (int j = 0; j < 65; j++) begin
            if (j == 32) d = 8'hC3;
            if (j == 40) cont = 1'b0;
            if (j == 31) chk("cont_sel_ch7", {29'd0, sel}, 32'd7);
            if (j == 32) begin
                chk("cont_sel_wrap", {29'd0, sel}, 32'd0);
                chk("cont_busy_wrap", {31'd0, busy}, 32'd1);
                chk("cont_snap1", {24'd0, snapshot}, 32'h3C);
            end
            if (j == 63) chk("cont_busy_late", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        chk("cont_busy_end", {31'd0, busy}, 32'd0);
        chk("cont_snap2", {24'd0, snapshot}, 32'hC3);

        // Start while busy (mid-scan and on the completion edge) is ignored
        d = 8'h5A;
        start_scan(8'h5A, 1'b1);
        for (int j = 0; j < 41; j++) begin
            start = (j == 10 || j == 31);
            if (j == 32) chk("restart_busy_done_edge", {31'd0, busy}, 32'd0);
            if (j == 33) chk("restart_busy_after", {31'd0, busy}, 32'd0);
            @(negedge clk);
        end
        start = 1'b0;
        chk("restart_busy_idle", {31'd0, busy}, 32'd0);

        // Reset in the middle of channel 4
        d = 8'hFF;
        start_scan(8'h00, 1'b0);
        for (int j = 0; j < 17; j++) @(negedge clk);
        chk("midrst_sel_before", {29'd0, sel}, 32'd4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_sel", {29'd0, sel}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_snapshot", {24'd0, snapshot}, 32'h00);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        d = 8'h96;
        start_scan(8'h96, 1'b1);
        repeat (33) @(negedge clk);
        chk("postrst_busy", {31'd0, busy}, 32'd0);
        chk("postrst_snapshot", {24'd0, snapshot}, 32'h96);
        chk("postrst_valid", {31'd0, valid}, 32'd1);

        // rst and start together in IDLE
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("rststart_busy", {31'd0, busy}, 32'd0);
        chk("rststart_sel", {29'd0, sel}, 32'd0);
        chk("rststart_valid", {31'd0, valid}, 32'd0);
        repeat (40) @(negedge clk);
        chk("rststart_busy_later", {31'd0, busy}, 32'd0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
